// File: rtl/apb_requester.sv
// APB4 requester: accepts one local command at a time, runs a SETUP/ACCESS
// transfer on the peripheral bus and returns a one-cycle response strobe.
// Misaligned commands are rejected locally, and an ACCESS phase that stalls
// for TIMEOUT cycles is abandoned with an error.
module apb_requester #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  // Client command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  // Client response channel
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  // APB bus
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_W      = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [STRB_WIDTH-1:0]   r_pstrb;
  logic [2:0]              r_pprot;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;
  logic                    r_rsp_timeout;

  logic                    w_accept;
  logic                    w_misaligned;
  logic                    w_done;
  logic                    w_tout;
  logic                    w_psel;
  logic                    w_penable;

  // Low address bits under the byte-lane mask must be zero; masking avoids an
  // empty slice when the bus is one byte wide.
  assign w_misaligned = (cmd_addr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0;
  assign cmd_ready    = (r_state == StIdle) && presetn;

  // Next-state decode and bus control outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_tout       = 1'b0;
    w_psel       = 1'b0;
    w_penable    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          w_accept = 1'b1;
          if (!w_misaligned) w_state_next = StSetup;
        end
      end
      StSetup: begin
        w_psel       = 1'b1;
        w_state_next = StAccess;
      end
      StAccess: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        // pready wins over a timeout landing in the same cycle.
        if (pready) begin
          w_done       = 1'b1;
          w_state_next = StIdle;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_tout       = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register and ACCESS cycle counter (zero outside ACCESS).
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= (r_state == StAccess) ? r_cnt + CNT_W'(1) : '0;
    end
  end

  // Command capture and response generation.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
        r_pstrb  <= cmd_write ? cmd_strb : '0;
        r_pprot  <= cmd_prot;
      end
      r_rsp_valid   <= w_done || w_tout || (w_accept && w_misaligned);
      r_rsp_err     <= (w_done && pslverr) || w_tout || (w_accept && w_misaligned);
      r_rsp_timeout <= w_tout;
      r_rsp_rdata   <= (w_done && !r_pwrite && !pslverr) ? prdata : '0;
    end
  end

  assign psel        = w_psel;
  assign penable     = w_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = r_pprot;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: fixed vector table, reset sequences and random
// transactions checked against a transaction-level expectation model.
module tb_apb_requester;

  localparam int TO = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;

  apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // waits: ACCESS cycles with pready=0 before pready=1 (>= TO means never).
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    int          lat;
    logic        err;
    logic        tout;
    logic [31:0] rdata;
    int          acc;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected outcome from the transfer rules: latency counted from accept edge.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.addr[1:0] != 2'b00) begin
      r.lat = 1; r.err = 1'b1; r.tout = 1'b0; r.rdata = 32'h0; r.acc = 0;
    end else if (v.waits < TO) begin
      r.lat = 3 + v.waits; r.err = v.slverr; r.tout = 1'b0;
      r.rdata = (!v.wr && !v.slverr) ? v.prdata : 32'h0;
      r.acc = v.waits + 1;
    end else begin
      r.lat = 2 + TO; r.err = 1'b1; r.tout = 1'b1; r.rdata = 32'h0; r.acc = TO;
    end
    return r;
  endfunction

  // Issue one command (called #1 after a rising edge) and act as the completer.
  task automatic run(input vec_t v, input string tag);
    int          acc = 0;
    int          setups = 0;
    int          lat = -1;
    logic        ok = 1'b1;
    logic        got = 1'b0;
    logic        rdy_at_rsp = 1'b0;
    logic        r_err = 1'b0, r_tout = 1'b0;
    logic [31:0] r_data = 32'h0;
    logic        mis = (v.addr[1:0] != 2'b00);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    cmd_strb = v.strb; cmd_prot = v.prot;
    chk({tag, "_ready"}, cmd_ready, 1);
    @(posedge pclk); #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~v.wr;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      // Junk on the response inputs outside a completing ACCESS cycle.
      pready = 1'b1; pslverr = 1'b1; prdata = $urandom;
      if (psel) begin
        if (paddr !== v.addr || pwrite !== v.wr || pwdata !== v.wdata ||
            pstrb !== (v.wr ? v.strb : 4'h0) || pprot !== v.prot) ok = 1'b0;
        if (penable) begin
          pready  = (acc == v.waits);
          pslverr = pready ? v.slverr : 1'b1;
          prdata  = pready ? v.prdata : $urandom;
          acc++;
        end else begin
          setups++;
        end
      end
      if (rsp_valid) begin
        got = 1'b1; lat = cyc; r_err = rsp_err; r_tout = rsp_timeout; r_data = rsp_rdata;
        rdy_at_rsp = cmd_ready;
      end
      @(posedge pclk); #1;
    end
    pready = 1'b0; pslverr = 1'b0;
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_err"}, r_err, v.err);
    chk({tag, "_tout"}, r_tout, v.tout);
    chk({tag, "_rdata"}, r_data, v.rdata);
    chk({tag, "_access_cycles"}, acc, v.acc);
    chk({tag, "_setup_cycles"}, setups, mis ? 0 : 1);
    chk({tag, "_bus_stable"}, ok, 1);
    chk({tag, "_ready_at_rsp"}, rdy_at_rsp, 1);
    chk({tag, "_rsp_one_cycle"}, rsp_valid, 0);
  endtask

  vec_t tbl [8];
  vec_t rv;
  logic [31:0] a;
  logic quiet;

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0; cmd_prot = 0;
    pready = 0; pslverr = 0; prdata = 0;

    //          wr   addr          wdata         strb  prot waits slv  prdata  lat err tout rdata acc
    tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0,  1'b0, 32'h0,        3, 1'b0, 1'b0, 32'h0,        1};
    tbl[1] = '{1'b0, 32'h10, 32'h11111111, 4'hF, 3'd2, 2,  1'b0, 32'hDEADBEEF, 5, 1'b0, 1'b0, 32'hDEADBEEF, 3};
    tbl[2] = '{1'b0, 32'h22, 32'h0,        4'hF, 3'd0, 0,  1'b0, 32'h5555,     1, 1'b1, 1'b0, 32'h0,        0};
    tbl[3] = '{1'b1, 32'h40, 32'hCAFEF00D, 4'h5, 3'd5, 0,  1'b1, 32'h0,        3, 1'b1, 1'b0, 32'h0,        1};
    tbl[4] = '{1'b0, 32'h44, 32'h0,        4'hF, 3'd1, 1,  1'b1, 32'h1234,     4, 1'b1, 1'b0, 32'h0,        2};
    tbl[5] = '{1'b0, 32'h48, 32'h0,        4'h3, 3'd7, TO, 1'b0, 32'h9999,     6, 1'b1, 1'b1, 32'h0,        4};
    tbl[6] = '{1'b0, 32'h4C, 32'h0,        4'h0, 3'd3, 3,  1'b0, 32'hA5A5A5A5, 6, 1'b0, 1'b0, 32'hA5A5A5A5, 4};
    tbl[7] = '{1'b1, 32'h13, 32'h77777777, 4'hF, 3'd4, 0,  1'b0, 32'h0,        1, 1'b1, 1'b0, 32'h0,        0};

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_ctrl", {psel, penable, pwrite, pprot, pstrb, rsp_valid, rsp_err, rsp_timeout}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    presetn = 1'b1;
    #1;
    chk("rst_release_ready", cmd_ready, 1);

    for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted during ACCESS: bus drops at once, no response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; cmd_strb = 4'hF; cmd_prot = 3'd1;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !penable; i++) begin
      @(posedge pclk); #1;
    end
    chk("mid_rst_in_access", penable, 1);
    presetn = 1'b0;
    @(posedge pclk); #1;
    chk("mid_rst_bus", {psel, penable}, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_paddr", paddr, 0);
    chk("mid_rst_ready_low", cmd_ready, 0);
    presetn = 1'b1;
    #1;
    chk("mid_rst_ready_high", cmd_ready, 1);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      if (rsp_valid || psel) quiet = 1'b0;
    end
    chk("mid_rst_quiet", quiet, 1);

    // Random transactions against the model
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      rv.wr = 1'($urandom_range(0, 1));
      rv.addr = a;
      rv.wdata = $urandom;
      rv.strb = 4'($urandom_range(0, 15));
      rv.prot = 3'($urandom_range(0, 7));
      rv.waits = $urandom_range(0, TO + 1);
      rv.slverr = ($urandom_range(0, 3) == 0);
      rv.prdata = $urandom;
      run(model(rv), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
